firebird7_in_gate1_tessent_tdr_w3: RTL
======================================

FIREBIRD7_IN_GATE1_TESSENT_TDR_W3 -- requirements
Module: firebird7_in_gate1_tessent_tdr_w3

Interface
REQ-001 SHALL have parameter WIDTH, default 3, which is the width of the functional data path under IJTAG control.
REQ-002 SHALL have port ijtag_tck, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port ijtag_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port ijtag_sel, input, 1 bit: selects this segment in the active scan path.
REQ-005 SHALL have port ijtag_si, input, 1 bit: scan-in data.
REQ-006 SHALL have ports ijtag_ce, ijtag_se and ijtag_ue, each input, 1 bit: capture, shift and update enables.
REQ-007 SHALL have port ijtag_so, output, 1 bit: scan-out data.
REQ-008 SHALL have port functional_data_obs, input, WIDTH bits: functional value observed at capture.
REQ-009 SHALL have port ijtag_select, output, 1 bit: override enable that drives the select of the data mux.
REQ-010 SHALL have port ijtag_data_out, output, WIDTH bits: override value that drives the IJTAG data input of the data mux.

Function
REQ-011 SHALL hold a shift register SR of WIDTH+1 bits: SR[WIDTH] is the select bit; SR[WIDTH-1:0] is the data field.
REQ-012 SHALL hold an update register UR of WIDTH+1 bits laid out the same way; ijtag_select = UR[WIDTH] and ijtag_data_out = UR[WIDTH-1:0], both driven directly from flops with no combinational path from inputs.
REQ-013 SHALL hold SR and UR unchanged on every edge where ijtag_sel=0; ijtag_so still reflects SR[0].
REQ-014 Capture: with sel=1 and ce=1, SR SHALL load {UR[WIDTH], functional_data_obs} on the next edge (latency 1).
REQ-015 Shift: with sel=1, se=1 and ce=0, SR SHALL load {ijtag_si, SR[WIDTH:1]}, so that SI enters at the MSB and SR[0] exits.
REQ-016 ijtag_so SHALL equal SR[0] combinationally from the flop, giving a scan length of exactly WIDTH+1 cycles.
REQ-017 Update: with sel=1 and ue=1, UR SHALL load the pre-edge value of SR; outputs change 1 cycle after the ue edge.
REQ-018 When ce and se are both 1, capture SHALL win and the shift SHALL be dropped.
REQ-019 When ue=1 together with ce or se, UR SHALL take the pre-edge SR while SR performs its own operation in the same edge.
REQ-020 Shift SHALL not wrap: after WIDTH+1 shifts, SR holds only the last WIDTH+1 SI bits, and older bits are lost out of SO.
REQ-021 While UR[WIDTH]=0, ijtag_data_out SHALL still present UR[WIDTH-1:0], because the mux ignores it in that state.

Reset
REQ-022 ijtag_reset=1 SHALL clear SR and UR to all zeros asynchronously, giving ijtag_select=0, ijtag_data_out=0 and ijtag_so=0 without a clock edge.
REQ-023 A reset asserted mid-shift or mid-update SHALL abort the operation and leave no partial state after release.
REQ-024 Deassertion SHALL take effect at the next rising ijtag_tck edge; no enable is honoured on the edge where reset is still high.

Structure
REQ-025 Shared package firebird7_in_gate1_tessent_tdr_pkg SHALL hold the bit positions SEL_BIT=WIDTH and DATA_LSB=0, plus the reset value constant (all zeros).
REQ-026 SHALL contain no sub-modules beyond one natural one, firebird7_in_gate1_tessent_tdr_cell, a single SR/UR bit pair that is instantiated WIDTH+1 times.
REQ-027 The block SHALL be connected so that ijtag_select and ijtag_data_out feed the existing W3 data mux directly.

Verification
REQ-028 Reset then shift 4 bits 1,0,1,1 (SI order), then ue: required result is ijtag_select=1 and ijtag_data_out=3'b101 one cycle after ue.
REQ-029 With functional_data_obs=3'b110 and UR select=1, apply ce then 4 shifts: required ijtag_so sequence is 0,1,1,1.
REQ-030 Drive sel=0 with se=1 and ue=1 for 10 cycles: required result is SR, UR and all outputs unchanged.
REQ-031 Drive ce=se=1 in the same cycle with obs=3'b011: required result is SR=4'b0011 after capture (select bit 0 from UR), with no shift.
REQ-032 Assert reset asynchronously between tck edges in mid-shift with ijtag_select=1: required result is all outputs 0 immediately, and the first scan after release reads 4'b0000 before capture.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared constants for the firebird7 input-gate IJTAG test data register.
// The register holds one select bit at the top and the data field at the bottom.
package firebird7_in_gate1_tessent_tdr_pkg;

  localparam int TDR_WIDTH = 3;
  localparam int SEL_BIT   = TDR_WIDTH;
  localparam int DATA_LSB  = 0;

  localparam logic [SEL_BIT:0] RESET_VAL = '0;
  localparam logic             RESET_BIT = 1'b0;

  // Select-bit position for a data field of the given width.
  function automatic int sel_bit(input int width);
    return width;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_cell.sv
// One shift/update bit pair of the test data register.
// Capture has priority over shift; update samples the pre-edge shift bit.
module firebird7_in_gate1_tessent_tdr_cell
  import firebird7_in_gate1_tessent_tdr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sel,
  input  logic ce,
  input  logic se,
  input  logic ue,
  input  logic capture_in,
  input  logic shift_in,
  output logic sr_bit,
  output logic ur_bit
);

  // NOTE: non-blocking assignments make ur_bit see the pre-edge sr_bit
  // even when capture or shift updates sr_bit in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_bit <= RESET_BIT;
      ur_bit <= RESET_BIT;
    end else if (sel) begin
      if (ce) begin
        sr_bit <= capture_in;
      end else if (se) begin
        sr_bit <= shift_in;
      end
      if (ue) begin
        ur_bit <= sr_bit;
      end
    end
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w3.sv
// IJTAG data register that overrides the W3 data mux: select bit plus WIDTH data bits.
// Outputs come straight from the update flops so the mux never sees scan activity.
module firebird7_in_gate1_tessent_tdr_w3
  import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_si,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_obs,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out
);

  localparam int SEL = sel_bit(WIDTH);

  logic [SEL:0] sr;
  logic [SEL:0] ur;
  logic [SEL:0] capture_vec;
  logic [SEL:0] shift_vec;

  // Capture keeps the current override select so a capture cannot drop the override.
  assign capture_vec = {ur[SEL], functional_data_obs};
  assign shift_vec   = {ijtag_si, sr[SEL:DATA_LSB+1]};

  for (genvar i = 0; i <= SEL; i++) begin : g_bit
    firebird7_in_gate1_tessent_tdr_cell u_cell (
      .clk        (ijtag_tck),
      .rst        (ijtag_reset),
      .sel        (ijtag_sel),
      .ce         (ijtag_ce),
      .se         (ijtag_se),
      .ue         (ijtag_ue),
      .capture_in (capture_vec[i]),
      .shift_in   (shift_vec[i]),
      .sr_bit     (sr[i]),
      .ur_bit     (ur[i])
    );
  end

  assign ijtag_so       = sr[DATA_LSB];
  assign ijtag_select   = ur[SEL];
  assign ijtag_data_out = ur[SEL-1:DATA_LSB];

endmodule
